// File: rtl/hiscore_xfer_ctrl_if.sv
// High-score RAM access bus between the transfer controller (master) and the game core (slave).
interface hiscore_xfer_ctrl_if;
  // Protocol: the master owns the core RAM port while hs_access=1. Reads: hs_address is held
  // stable and hs_data_out is valid RD_LAT cycles later. Writes: hs_write=1 for one cycle with
  // hs_address/hs_data_in valid; hs_write is only ever 1 while hs_access=1, and hs_data_in is 0
  // whenever hs_write=0.
  logic [15:0] hs_address;
  logic [7:0]  hs_data_in;
  logic [7:0]  hs_data_out;
  logic        hs_write;
  logic        hs_access;

  modport master (
    output hs_address,
    output hs_data_in,
    output hs_write,
    output hs_access,
    input  hs_data_out
  );

  modport slave (
    input  hs_address,
    input  hs_data_in,
    input  hs_write,
    input  hs_access,
    output hs_data_out
  );
endinterface

// File: rtl/hiscore_xfer_ctrl.sv
// High-score save/restore initiator: host-loaded byte buffer <-> game core RAM.
// Optional macro HISCORE_READBACK_EN adds a read-back verify pass after each restore.
module hiscore_xfer_ctrl #(
  parameter logic [15:0] HS_BASE      = 16'h0000,
  parameter int          HS_LEN       = 64,
  parameter logic [7:0]  START_VAL    = 8'h00,
  parameter logic [7:0]  END_VAL      = 8'h00,
  parameter int          RD_LAT       = 2,
  parameter int          CHK_INTERVAL = 4800000,
  parameter int          MAX_TRIES    = 20
) (
  input  logic                       clk48M,
  input  logic                       reset,
  input  logic                       restore_req,
  input  logic                       save_req,
  input  logic [9:0]                 host_addr,
  input  logic [7:0]                 host_din,
  input  logic                       host_wr,
  output logic [7:0]                 host_dout,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic                       pause_req,
  output logic [2:0]                 dbg_state,
  hiscore_xfer_ctrl_if.master        hs
);
  localparam int              AW        = (HS_LEN > 1) ? $clog2(HS_LEN) : 1;
  localparam int              TW        = $clog2(MAX_TRIES + 1);
  localparam logic [9:0]      LAST_IDX  = 10'(HS_LEN - 1);
  localparam logic [15:0]     END_ADDR  = HS_BASE + 16'(HS_LEN - 1);
  localparam logic [31:0]     RD_LAST   = 32'(RD_LAT);
  localparam logic [31:0]     WAIT_LAST = 32'(CHK_INTERVAL - 1);
  localparam logic [TW-1:0]   TRIES_MAX = TW'(MAX_TRIES);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CHK_S   = 3'd1,
    CHK_E   = 3'd2,
    WAITCHK = 3'd3,
    WR      = 3'd4,
    RD      = 3'd5,
    VERIFY  = 3'd6,
    DONE    = 3'd7
  } state_t;

  state_t        state, state_d;
  logic [9:0]    idx, idx_d;
  logic [31:0]   cnt, cnt_d;
  logic [TW-1:0] tries, tries_d, tries_inc;
  logic          start_ok, start_ok_d;
  logic          phase, phase_d;
  logic          error_d;
  logic          rd_done, wr_a;
  logic          mem_we;
  logic [AW-1:0] mem_wa;
  logic [7:0]    mem_wd;
  logic [7:0]    buf_q;
  logic [7:0]    mem [0:HS_LEN-1];

  assign busy      = (state != IDLE) && (state != DONE);
  assign pause_req = busy && (state != WAITCHK);
  assign done      = (state == DONE);
  assign dbg_state = state;
  assign rd_done   = (cnt == RD_LAST);
  assign tries_inc = tries + TW'(1);
  assign wr_a      = (state == WR) && !phase;

  assign hs.hs_access  = pause_req;
  assign hs.hs_write   = wr_a;
  assign hs.hs_data_in = wr_a ? buf_q : 8'h00;
  always_comb begin
    hs.hs_address = 16'h0000;
    case (state)
      CHK_S:                  hs.hs_address = HS_BASE;
      CHK_E:                  hs.hs_address = END_ADDR;
      WR, RD, VERIFY:         hs.hs_address = HS_BASE + {6'b0, idx};
      default:                hs.hs_address = 16'h0000;
    endcase
  end

  always_ff @(posedge clk48M or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      cnt      <= '0;
      tries    <= '0;
      start_ok <= 1'b0;
      phase    <= 1'b0;
      error    <= 1'b0;
    end else begin
      state    <= state_d;
      idx      <= idx_d;
      cnt      <= cnt_d;
      tries    <= tries_d;
      start_ok <= start_ok_d;
      phase    <= phase_d;
      error    <= error_d;
    end
  end

  always_comb begin
    state_d    = state;
    idx_d      = idx;
    cnt_d      = cnt;
    tries_d    = tries;
    start_ok_d = start_ok;
    phase_d    = phase;
    error_d    = error;
    // Host writes land only while no transfer owns the buffer.
    mem_we     = !busy && host_wr && (host_addr <= LAST_IDX);
    mem_wa     = host_addr[AW-1:0];
    mem_wd     = host_din;
    case (state)
      IDLE: begin
        if (restore_req || save_req) begin
          state_d = restore_req ? CHK_S : RD;
          error_d = 1'b0;
          tries_d = '0;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      CHK_S: begin
        cnt_d = cnt + 32'd1;
        if (rd_done) begin
          start_ok_d = (hs.hs_data_out == START_VAL);
          cnt_d      = '0;
          state_d    = CHK_E;
        end
      end
      CHK_E: begin
        cnt_d = cnt + 32'd1;
        if (rd_done) begin
          cnt_d = '0;
          if (start_ok && (hs.hs_data_out == END_VAL)) begin
            state_d = WR;
            idx_d   = '0;
            phase_d = 1'b0;
          end else begin
            tries_d = tries_inc;
            if (tries_inc == TRIES_MAX) begin
              error_d = 1'b1;
              state_d = DONE;
            end else begin
              state_d = WAITCHK;
            end
          end
        end
      end
      WAITCHK: begin
        cnt_d = cnt + 32'd1;
        if (cnt == WAIT_LAST) begin
          cnt_d   = '0;
          state_d = CHK_S;
        end
      end
      WR: begin
        phase_d = ~phase;
        if (phase) begin
          if (idx == LAST_IDX) begin
            idx_d = '0;
            cnt_d = '0;
`ifdef HISCORE_READBACK_EN
            state_d = VERIFY;
`else
            state_d = DONE;
`endif
          end else begin
            idx_d = idx + 10'd1;
          end
        end
      end
      RD: begin
        cnt_d = cnt + 32'd1;
        if (rd_done) begin
          cnt_d  = '0;
          mem_we = 1'b1;
          mem_wa = idx[AW-1:0];
          mem_wd = hs.hs_data_out;
          if (idx == LAST_IDX) state_d = DONE;
          else                 idx_d   = idx + 10'd1;
        end
      end
`ifdef HISCORE_READBACK_EN
      VERIFY: begin
        cnt_d = cnt + 32'd1;
        if (rd_done) begin
          cnt_d = '0;
          if (hs.hs_data_out != buf_q) error_d = 1'b1;
          if (idx == LAST_IDX) state_d = DONE;
          else                 idx_d   = idx + 10'd1;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Internal port is addressed with the next index so buf_q always holds mem[idx].
  always_ff @(posedge clk48M) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
    buf_q <= mem[idx_d[AW-1:0]];
  end

  always_ff @(posedge clk48M or posedge reset) begin
    if (reset) host_dout <= 8'h00;
    else       host_dout <= (host_addr <= LAST_IDX) ? mem[host_addr[AW-1:0]] : 8'h00;
  end
endmodule

// File: tb/tb_hiscore_xfer_ctrl.sv
// Self-checking bench for hiscore_xfer_ctrl with a behavioural game-core RAM model.
module tb_hiscore_xfer_ctrl;
  localparam logic [15:0] HS_BASE      = 16'hFFE0;
  localparam int          HS_LEN       = 64;
  localparam logic [7:0]  START_VAL    = 8'h11;
  localparam logic [7:0]  END_VAL      = 8'h22;
  localparam int          RD_LAT       = 2;
  localparam int          CHK_INTERVAL = 10;
  localparam int          MAX_TRIES    = 4;
  localparam logic [15:0] END_ADDR     = HS_BASE + 16'(HS_LEN - 1);
  localparam int          T_RESTORE    = 2 * (RD_LAT + 1) + 2 * HS_LEN;

  // clock / reset
  logic clk48M = 1'b0;
  logic reset  = 1'b1;
  always #5 clk48M = ~clk48M;

  logic       restore_req = 1'b0, save_req = 1'b0, host_wr = 1'b0;
  logic [9:0] host_addr = '0;
  logic [7:0] host_din = '0;
  logic [7:0] host_dout;
  logic       busy, done, error, pause_req;
  logic [2:0] dbg_state;

  hiscore_xfer_ctrl_if bus ();

  hiscore_xfer_ctrl #(
    .HS_BASE(HS_BASE), .HS_LEN(HS_LEN), .START_VAL(START_VAL), .END_VAL(END_VAL),
    .RD_LAT(RD_LAT), .CHK_INTERVAL(CHK_INTERVAL), .MAX_TRIES(MAX_TRIES)
  ) dut (
    .clk48M(clk48M), .reset(reset), .restore_req(restore_req), .save_req(save_req),
    .host_addr(host_addr), .host_din(host_din), .host_wr(host_wr), .host_dout(host_dout),
    .busy(busy), .done(done), .error(error), .pause_req(pause_req), .dbg_state(dbg_state),
    .hs(bus.master)
  );

  // game core RAM model: RD_LAT=2 read pipeline, bench preload port, optional byte-5 corruption
  logic [7:0]  core_mem [0:65535];
  logic [7:0]  rd_p0, rd_p1;
  logic        pre_we = 1'b0;
  logic [15:0] pre_addr = '0;
  logic [7:0]  pre_data = '0;
  logic        corrupt = 1'b0;
  int          wr_cnt = 0, done_cnt = 0, viol_cnt = 0;
  assign bus.hs_data_out = rd_p1;

  always @(posedge clk48M) begin
    if (pre_we) core_mem[pre_addr] <= pre_data;
    else if (bus.hs_write && bus.hs_access)
      core_mem[bus.hs_address] <= (corrupt && bus.hs_address == HS_BASE + 16'd5) ?
                                  ~bus.hs_data_in : bus.hs_data_in;
    rd_p0 <= core_mem[bus.hs_address];
    rd_p1 <= rd_p0;
    if (bus.hs_write) wr_cnt <= wr_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if ((bus.hs_write && !bus.hs_access) || (!bus.hs_write && bus.hs_data_in != 8'h00))
      viol_cnt <= viol_cnt + 1;
  end

  // scoreboard
  logic [7:0] exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;

  // driver tasks
  task automatic host_write_byte(input logic [9:0] a, input logic [7:0] d);
    @(negedge clk48M);
    host_wr = 1'b1; host_addr = a; host_din = d;
    @(posedge clk48M); #1;
    host_wr = 1'b0;
  endtask

  task automatic host_read_byte(input logic [9:0] a, output logic [7:0] d);
    @(negedge clk48M);
    host_addr = a;
    @(negedge clk48M);
    d = host_dout;
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk48M);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk48M); #1;
    pre_we = 1'b0;
  endtask

  task automatic pulse_req(input logic r, input logic s);
    @(negedge clk48M);
    restore_req = r; save_req = s;
    @(negedge clk48M);
    restore_req = 1'b0; save_req = 1'b0;
  endtask

  task automatic wait_done(input int start, output int cycles);
    cycles = start;
    while (done !== 1'b1 && cycles < 2000) begin
      @(negedge clk48M);
      cycles++;
    end
  endtask

  // Watches a restore until done; optionally fixes START_VAL on entering the fix_at-th wait.
  task automatic run_restore_watch(input int fix_at, output int waits, output int wait_cyc,
                                   output int bad);
    int cyc;
    logic in_wait;
    waits = 0; wait_cyc = 0; bad = 0; cyc = 0; in_wait = 1'b0;
    pulse_req(1'b1, 1'b0);
    while (done !== 1'b1 && cyc < 2000) begin
      @(negedge clk48M);
      cyc++;
      pre_we = 1'b0;
      if (busy && !bus.hs_access) begin
        wait_cyc++;
        if (pause_req !== 1'b0) bad++;
        if (!in_wait) begin
          waits++;
          in_wait = 1'b1;
          if (waits == fix_at) begin
            pre_we = 1'b1; pre_addr = HS_BASE; pre_data = START_VAL;
          end
        end
      end else begin
        in_wait = 1'b0;
      end
    end
    pre_we = 1'b0;
  endtask

  task automatic check_core_from_queue(input string tag);
    logic [7:0] e;
    for (int i = 0; i < HS_LEN; i++) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (core_mem[HS_BASE + 16'(i)] !== e) begin
        n_fail++;
        $display("FAIL %s[%0d]: got %02h want %02h", tag, i, core_mem[HS_BASE + 16'(i)], e);
      end
    end
  endtask

  task automatic check_buffer_from_queue(input string tag);
    logic [7:0] d, e;
    for (int i = 0; i < HS_LEN; i++) begin
      host_read_byte(10'(i), d);
      e = exp_q.pop_front();
      n_cmp++;
      if (d !== e) begin
        n_fail++;
        $display("FAIL %s[%0d]: got %02h want %02h", tag, i, d, e);
      end
    end
  endtask

  // scenarios
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk48M);
    n_cmp++;
    if ({busy, done, error, pause_req, bus.hs_access, bus.hs_write} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %06b want 000000",
               {busy, done, error, pause_req, bus.hs_access, bus.hs_write});
    end
    n_cmp++;
    if ({bus.hs_address, bus.hs_data_in, host_dout} !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_buses: got %08h want 0", {bus.hs_address, bus.hs_data_in, host_dout});
    end
    n_cmp++;
    if (dbg_state !== 3'd0) begin
      n_fail++; $display("FAIL reset_state: got %0d want 0", dbg_state);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk48M);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_restore();
    int cyc, wr0, dn0;
    logic [7:0] d;
    for (int i = 0; i < HS_LEN; i++) begin
      host_write_byte(10'(i), 8'(i) ^ 8'hA5);
      exp_q.push_back(8'(i) ^ 8'hA5);
    end
    preload(HS_BASE, START_VAL);
    preload(END_ADDR, END_VAL);
    wr0 = wr_cnt; dn0 = done_cnt;
    @(negedge clk48M);
    restore_req = 1'b1;
    n_cmp++;
    if (bus.hs_access !== 1'b0) begin
      n_fail++; $display("FAIL restore_access_pre: got %b want 0", bus.hs_access);
    end
    @(negedge clk48M);
    restore_req = 1'b0;
    n_cmp++;
    if (bus.hs_access !== 1'b1) begin
      n_fail++; $display("FAIL restore_access_rise: got %b want 1", bus.hs_access);
    end
    host_wr = 1'b1; host_addr = 10'd3; host_din = 8'hEE;
    @(negedge clk48M);
    host_wr = 1'b0;
    wait_done(2, cyc);
    n_cmp++;
    if (done !== 1'b1) begin
      n_fail++; $display("FAIL restore_done: got %b want 1 (timeout)", done);
    end
    n_cmp++;
    if ((cyc - 1) < T_RESTORE - 2 || (cyc - 1) > T_RESTORE + 2) begin
      n_fail++; $display("FAIL restore_cycles: got %0d want %0d +-2", cyc - 1, T_RESTORE);
    end
    n_cmp++;
    if (error !== 1'b0) begin
      n_fail++; $display("FAIL restore_error: got %b want 0", error);
    end
    repeat (3) @(negedge clk48M);
    n_cmp++;
    if (wr_cnt - wr0 !== HS_LEN) begin
      n_fail++; $display("FAIL restore_writes: got %0d want %0d", wr_cnt - wr0, HS_LEN);
    end
    n_cmp++;
    if (done_cnt - dn0 !== 1) begin
      n_fail++; $display("FAIL restore_done_pulses: got %0d want 1", done_cnt - dn0);
    end
    check_core_from_queue("restore_core");
    host_read_byte(10'd3, d);
    n_cmp++;
    if (d !== (8'd3 ^ 8'hA5)) begin
      n_fail++; $display("FAIL restore_busy_wr_dropped: got %02h want %02h", d, 8'd3 ^ 8'hA5);
    end
  endtask

  task automatic test_sig_retry();
    int waits, wait_cyc, bad, wr0;
    preload(HS_BASE, ~START_VAL);
    preload(END_ADDR, END_VAL);
    wr0 = wr_cnt;
    run_restore_watch(3, waits, wait_cyc, bad);
    n_cmp++;
    if (done !== 1'b1) begin
      n_fail++; $display("FAIL retry_done: got %b want 1 (timeout)", done);
    end
    n_cmp++;
    if (waits !== 3 || wait_cyc !== 3 * CHK_INTERVAL) begin
      n_fail++;
      $display("FAIL retry_waits: got %0d waits/%0d cycles want 3/%0d", waits, wait_cyc,
               3 * CHK_INTERVAL);
    end
    n_cmp++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL retry_pause_in_wait: got %0d cycles with pause_req=1 want 0", bad);
    end
    n_cmp++;
    if (error !== 1'b0) begin
      n_fail++; $display("FAIL retry_error: got %b want 0", error);
    end
    repeat (3) @(negedge clk48M);
    n_cmp++;
    if (wr_cnt - wr0 !== HS_LEN) begin
      n_fail++; $display("FAIL retry_writes: got %0d want %0d", wr_cnt - wr0, HS_LEN);
    end
  endtask

  task automatic test_sig_timeout();
    int waits, wait_cyc, bad, wr0;
    preload(HS_BASE, ~START_VAL);
    preload(END_ADDR, END_VAL);
    wr0 = wr_cnt;
    run_restore_watch(0, waits, wait_cyc, bad);
    n_cmp++;
    if (done !== 1'b1 || error !== 1'b1) begin
      n_fail++; $display("FAIL timeout_done_error: got done=%b error=%b want 1/1", done, error);
    end
    n_cmp++;
    if (waits !== MAX_TRIES - 1) begin
      n_fail++; $display("FAIL timeout_waits: got %0d want %0d", waits, MAX_TRIES - 1);
    end
    repeat (5) @(negedge clk48M);
    n_cmp++;
    if (wr_cnt - wr0 !== 0) begin
      n_fail++; $display("FAIL timeout_writes: got %0d want 0", wr_cnt - wr0);
    end
    n_cmp++;
    if (error !== 1'b1) begin
      n_fail++; $display("FAIL timeout_error_sticky: got %b want 1", error);
    end
  endtask

  task automatic test_save();
    int cyc, wr0;
    for (int i = 0; i < HS_LEN; i++) begin
      preload(HS_BASE + 16'(i), 8'h30 + 8'(i));
      exp_q.push_back(8'h30 + 8'(i));
    end
    wr0 = wr_cnt;
    pulse_req(1'b0, 1'b1);
    n_cmp++;
    if (error !== 1'b0 || bus.hs_access !== 1'b1) begin
      n_fail++;
      $display("FAIL save_accept: got error=%b access=%b want 0/1", error, bus.hs_access);
    end
    wait_done(1, cyc);
    n_cmp++;
    if (done !== 1'b1) begin
      n_fail++; $display("FAIL save_done: got %b want 1 (timeout)", done);
    end
    repeat (3) @(negedge clk48M);
    n_cmp++;
    if (wr_cnt - wr0 !== 0) begin
      n_fail++; $display("FAIL save_writes: got %0d want 0", wr_cnt - wr0);
    end
    check_buffer_from_queue("save_buffer");
  endtask

  task automatic test_simul_req();
    int cyc, wr0, dn0;
    preload(HS_BASE, START_VAL);
    preload(END_ADDR, END_VAL);
    for (int i = 0; i < HS_LEN; i++) exp_q.push_back(8'h30 + 8'(i));
    wr0 = wr_cnt; dn0 = done_cnt;
    pulse_req(1'b1, 1'b1);
    repeat (20) @(negedge clk48M);
    pulse_req(1'b0, 1'b1);
    wait_done(1, cyc);
    n_cmp++;
    if (done !== 1'b1) begin
      n_fail++; $display("FAIL simul_done: got %b want 1 (timeout)", done);
    end
    repeat (300) @(negedge clk48M);
    n_cmp++;
    if (done_cnt - dn0 !== 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_single_op: got %0d done pulses busy=%b want 1/0", done_cnt - dn0, busy);
    end
    n_cmp++;
    if (wr_cnt - wr0 !== HS_LEN) begin
      n_fail++; $display("FAIL simul_restore_wins: got %0d writes want %0d", wr_cnt - wr0, HS_LEN);
    end
    check_core_from_queue("simul_core");
  endtask

  task automatic test_reset_mid_wr();
    int cyc;
    for (int i = 0; i < HS_LEN; i++) begin
      host_write_byte(10'(i), 8'(i) ^ 8'hA5);
      exp_q.push_back(8'(i) ^ 8'hA5);
    end
    preload(HS_BASE, START_VAL);
    preload(END_ADDR, END_VAL);
    pulse_req(1'b1, 1'b0);
    cyc = 0;
    while (!(bus.hs_write === 1'b1 && bus.hs_address === HS_BASE + 16'd10) && cyc < 500) begin
      @(negedge clk48M);
      cyc++;
    end
    n_cmp++;
    if (bus.hs_write !== 1'b1) begin
      n_fail++; $display("FAIL midwr_reached: got hs_write=%b want 1 (timeout)", bus.hs_write);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, error, pause_req, bus.hs_access, bus.hs_write} !== 6'b0 ||
        {bus.hs_address, bus.hs_data_in, host_dout} !== 32'h0) begin
      n_fail++;
      $display("FAIL midwr_async_outputs: got flags=%06b buses=%08h want 0/0",
               {busy, done, error, pause_req, bus.hs_access, bus.hs_write},
               {bus.hs_address, bus.hs_data_in, host_dout});
    end
    repeat (2) @(negedge clk48M);
    reset = 1'b0;
    n_cmp++;
    if (core_mem[HS_BASE + 16'd10] !== 8'h3A || core_mem[HS_BASE + 16'd9] !== (8'd9 ^ 8'hA5)) begin
      n_fail++;
      $display("FAIL midwr_partial: got b9=%02h b10=%02h want %02h/3a",
               core_mem[HS_BASE + 16'd9], core_mem[HS_BASE + 16'd10], 8'd9 ^ 8'hA5);
    end
    check_buffer_from_queue("midwr_buffer");
    preload(HS_BASE, START_VAL);
    for (int i = 0; i < HS_LEN; i++) exp_q.push_back(8'(i) ^ 8'hA5);
    pulse_req(1'b1, 1'b0);
    wait_done(1, cyc);
    n_cmp++;
    if (done !== 1'b1 || error !== 1'b0) begin
      n_fail++; $display("FAIL midwr_rerun: got done=%b error=%b want 1/0", done, error);
    end
    repeat (3) @(negedge clk48M);
    check_core_from_queue("midwr_core");
  endtask

  task automatic test_readback();
    int cyc;
    preload(HS_BASE, START_VAL);
    preload(END_ADDR, END_VAL);
    corrupt = 1'b1;
    pulse_req(1'b1, 1'b0);
    wait_done(1, cyc);
    n_cmp++;
    if (done !== 1'b1) begin
      n_fail++; $display("FAIL readback_done: got %b want 1 (timeout)", done);
    end
`ifdef HISCORE_READBACK_EN
    n_cmp++;
    if (error !== 1'b1) begin
      n_fail++; $display("FAIL readback_error: got %b want 1", error);
    end
`else
    n_cmp++;
    if (error !== 1'b0) begin
      n_fail++; $display("FAIL readback_absent_error: got %b want 0", error);
    end
`endif
    repeat (3) @(negedge clk48M);
    corrupt = 1'b0;
  endtask

  initial begin
    test_reset();
    test_restore();
    test_sig_retry();
    test_sig_timeout();
    test_save();
    test_simul_req();
    test_reset_mid_wr();
    test_readback();
    n_cmp++;
    if (viol_cnt !== 0) begin
      n_fail++; $display("FAIL bus_rules: got %0d violating cycles want 0", viol_cnt);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
